// File: rtl/polyshift_left_pkg.sv
// Shared shift-utility definitions: mode encoding and amount width common to the
// left and right polyshift blocks.
package polyshift_left_pkg;

    localparam int unsigned ShiftAmtWidth = 3;

    typedef enum logic [1:0] {
        SHL = 2'd0,
        SAL = 2'd1,
        RCL = 2'd2,
        ROL = 2'd3
    } shift_type_e;

endpackage

// File: rtl/polyshift_l_core.sv
// Combinational multi-mode left barrel shifter. A 2*word_width working vector
// {D_IN, fill} passes through x1/x2/x4 stages; the result is its upper half.
module polyshift_l_core
    import polyshift_left_pkg::*;
#(
    parameter int unsigned word_width = 8
) (
    input  logic [word_width-1:0]    D_IN,
    input  logic [word_width-2:0]    C_IN,
    input  logic [ShiftAmtWidth-1:0] shift_size,
    input  shift_type_e              shift_type,
    output logic [word_width-1:0]    result
);

    localparam int unsigned W2 = 2 * word_width;

    logic [word_width-1:0] fill;
    logic [W2-1:0]         stage0;
    logic [W2-1:0]         stage1;
    logic [W2-1:0]         stage2;
    logic [W2-1:0]         stage3;
    logic                  unused_lo;

    // The lower half supplies the bits that enter from the right; once it runs
    // out, zeros follow, which gives the no-modulo behaviour for large shifts.
    always_comb begin
        fill = '0;
        unique case (shift_type)
            SHL, SAL: fill = '0;
            RCL:      fill = {C_IN, 1'b0};
            ROL:      fill = D_IN;
            default:  fill = '0;
        endcase
    end

    always_comb begin
        stage0 = {D_IN, fill};
        stage1 = shift_size[0] ? (stage0 << 1) : stage0;
        stage2 = shift_size[1] ? (stage1 << 2) : stage1;
        stage3 = shift_size[2] ? (stage2 << 4) : stage2;
    end

    assign result    = stage3[W2-1:word_width];
    assign unused_lo = ^stage3[word_width-1:0];

endmodule

// File: rtl/polyshift_left.sv
// Registered multi-mode left shifter: combinational core plus one output
// register with synchronous active-low reset.
module polyshift_left
    import polyshift_left_pkg::*;
#(
    parameter int unsigned word_width = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [word_width-1:0]    D_IN,
    input  logic [word_width-2:0]    C_IN,
    input  logic [ShiftAmtWidth-1:0] shift_size,
    input  shift_type_e              shift_type,
    output logic [word_width-1:0]    D_OUT
);

    logic [word_width-1:0] result_d;
    logic [word_width-1:0] result_q;

    polyshift_l_core #(
        .word_width (word_width)
    ) u_core (
        .D_IN       (D_IN),
        .C_IN       (C_IN),
        .shift_size (shift_size),
        .shift_type (shift_type),
        .result     (result_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign D_OUT = result_q;

endmodule

// File: tb/tb_polyshift_left.sv
// Directed and swept checks of polyshift_left (word_width = 8) with immediate
// assertions and a formula-level reference.
module tb_polyshift_left;
    import polyshift_left_pkg::*;

    localparam int unsigned W = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  d_in;
    logic [W-2:0]  c_in;
    logic [2:0]    shift_size;
    shift_type_e   shift_type;
    logic [W-1:0]  d_out;

    int n_checks = 0;
    int n_errors = 0;

    polyshift_left #(
        .word_width (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D_IN       (d_in),
        .C_IN       (c_in),
        .shift_size (shift_size),
        .shift_type (shift_type),
        .D_OUT      (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-2:0] c,
                                           input logic [2:0] s, input shift_type_e t);
        logic [2*W-1:0] v;
        logic [W-1:0]   r;
        r = '0;
        case (t)
            SHL: r = d << s;
            SAL: r = $signed(d) <<< s;
            RCL: begin
                v = {d, c, 1'b0} << s;
                r = v[2*W-1:W];
            end
            default: begin
                v = {d, d} << s;
                r = v[2*W-1:W];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] exp);
        n_checks++;
        assert (d_out === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, d_out, exp);
        end
    endtask

    // Present inputs, let one rising edge capture them, sample 1 time unit later.
    task automatic step(input logic [W-1:0] d, input logic [W-2:0] c,
                        input logic [2:0] s, input shift_type_e t);
        d_in       = d;
        c_in       = c;
        shift_size = s;
        shift_type = t;
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] DV = 8'b1011_0001;
    localparam logic [W-2:0] CV = 7'b110_0101;

    initial begin
        rst_n      = 1'b0;
        d_in       = '0;
        c_in       = '0;
        shift_size = '0;
        shift_type = SHL;

        // Reset with nonzero inputs for two edges.
        step(DV, CV, 3'd3, ROL);
        check("reset_edge1", 8'h00);
        step(DV, CV, 3'd5, RCL);
        check("reset_edge2", 8'h00);
        rst_n = 1'b1;
        step(DV, CV, 3'd3, ROL);
        check("release_first", 8'b1000_1101);

        for (int t = 0; t < 4; t++) begin
            step(DV, CV, 3'd0, shift_type_e'(t));
            check($sformatf("s0_type%0d", t), 8'b1011_0001);
        end

        step(DV, CV, 3'd3, SHL);
        check("s3_shl", 8'b1000_1000);
        step(DV, CV, 3'd3, SAL);
        check("s3_sal", 8'b1000_1000);
        step(DV, CV, 3'd3, RCL);
        check("s3_rcl", 8'b1000_1110);
        step(DV, CV, 3'd3, ROL);
        check("s3_rol", 8'b1000_1101);

        step(DV, CV, 3'd7, SHL);
        check("s7_shl", 8'b1000_0000);
        step(DV, CV, 3'd7, SAL);
        check("s7_sal", 8'b1000_0000);
        step(DV, CV, 3'd7, RCL);
        check("s7_rcl", 8'b1110_0101);
        step(DV, CV, 3'd7, ROL);
        check("s7_rol", 8'b1101_1000);

        // Reset between back-to-back operations.
        step(DV, CV, 3'd1, ROL);
        check("b2b_before", 8'b0110_0011);
        rst_n = 1'b0;
        step(8'hFF, 7'h7F, 3'd2, RCL);
        check("b2b_reset", 8'h00);
        rst_n = 1'b1;
        step(DV, CV, 3'd2, RCL);
        check("b2b_after", 8'b1100_0111);

        // Sweep every type and amount, new random inputs every cycle.
        for (int rep = 0; rep < 4; rep++) begin
            for (int t = 0; t < 4; t++) begin
                for (int s = 0; s < 8; s++) begin
                    logic [W-1:0] rd;
                    logic [W-2:0] rc;
                    rd = W'($urandom);
                    rc = (W-1)'($urandom);
                    step(rd, rc, 3'(s), shift_type_e'(t));
                    check($sformatf("sweep_t%0d_s%0d_d%02h_c%02h", t, s, rd, rc),
                          model(rd, rc, 3'(s), shift_type_e'(t)));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/polyshift_left.md
# polyshift_left

Registered multi-mode left shifter for the shared utility library. Shifts a `word_width`-bit word left by 0–7 positions in one of four modes: logical, arithmetic, rotate-through-carry-word and rotate. The result is captured in an output register one clock after the inputs are presented. It is the left-hand counterpart of the library's right polyshift and is used by ALU/shift datapaths.

## Interface
- `word_width`, default 8: data word width in bits; legal range ≥ 2 (8 is the reference configuration).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `D_IN`  in  `word_width`: data word to shift.
- `C_IN`  in  `word_width-1`: extension word; supplies fill bits for RCL, MSB first.
- `shift_size`  in  3: shift amount, 0–7, unsigned.
- `shift_type`  in  `SHIFT_TYPE` (2-bit enum): mode select.
- `D_OUT`  out  `word_width`: registered shift result.

## Operation
- `SHIFT_TYPE` encodings:
  - 0 `SHL`: logical left. `D_OUT = D_IN << s`, zero fill.
  - 1 `SAL`: arithmetic left. `D_OUT = $signed(D_IN) <<< s`, which is bit-identical to SHL.
  - 2 `RCL`: shift through the extension word. Form the 2·`word_width` vector {D_IN, C_IN, 1'b0}, shift it left by s, and take the upper `word_width` bits.
    - Vacated LSBs take C_IN[w-2], C_IN[w-3], … in that order.
    - If s exceeds `word_width-1` (possible only when `word_width` < 8), the next fill bit is the constant 0, then lower bits per the formula.
  - 3 `ROL`: rotate left. Upper `word_width` bits of ({D_IN, D_IN} << s).
    - For s ≥ `word_width`, the result equals the upper `word_width` bits of that 2·`word_width` vector shifted by s, with zeros entering from the right; no modulo reduction is applied.
- s = 0 passes D_IN through unchanged in every mode.
- In SHL/SAL, shifts of `word_width` or more yield all zeros.
- No flags or carry-out are produced. C_IN is ignored in all modes except RCL.
- The datapath is purely combinational up to the single output register (3-stage barrel: ×1, ×2, ×4, each stage mode-aware).

## Timing
- Latency 1 cycle: inputs sampled at rising edge N appear on D_OUT after edge N.
- Full throughput: a new operation can be issued every cycle. There is no handshake and no stall.
- Reset: `rst_n` = 0 at a rising edge forces D_OUT = 0. This takes priority over any input.
  - The first result after reset is released reflects the inputs sampled at the first edge with `rst_n` = 1.
- Reset asserted mid-stream discards the in-flight result. No other state exists.
- Inputs must be stable across the setup window only; glitches between edges have no effect.

## Structure
- `SHIFT_TYPE` enum (SHL=0, SAL=1, RCL=2, ROL=3) lives in the shared utilities package, also used by the right polyshift.
- One natural sub-module: `polyshift_l_core`, the combinational barrel shifter (D_IN, C_IN, shift_size, shift_type → result).
  - `polyshift_left` instantiates the core and adds the reset/output register.

## Test plan
All cases use `word_width` = 8, D_IN = 8'b1011_0001, C_IN = 7'b110_0101. Each check is made one cycle after the inputs are applied.

- s = 0, every type → D_OUT = 1011_0001.
- s = 3: SHL → 1000_1000; SAL → 1000_1000; RCL → 1000_1110; ROL → 1000_1101.
- s = 7: SHL/SAL → 1000_0000; RCL → 1110_0101; ROL → 1101_1000.
- Exhaustive sweep, all 4 types × s 0–7 over random D_IN/C_IN. Compare against the formula model, one cycle late; change inputs every cycle to confirm full throughput.
- Reset: drive `rst_n` = 0 for 2 edges with nonzero inputs → D_OUT = 0. Release → the next edge loads the correct result.
- Assert reset between two back-to-back operations → D_OUT = 0 on that edge; the following operation is correct.
